// File: rtl/ip_arp_mc.sv
// Multi-channel next-hop MAC resolver: round-robin arbitration into one shared IP->MAC table,
// with per-channel result FIFOs popped in lockstep, a register port and per-channel miss counters.
module ip_arp_mc #(
  parameter int NUM_QUEUES      = 8,
  parameter int NUM_CHAN        = 2,
  parameter int LUT_DEPTH       = 32,
  parameter int LUT_DEPTH_BITS  = $clog2(LUT_DEPTH),
  parameter int META_WIDTH      = 3,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHAN-1:0]              ch_req_vld,
  output logic [NUM_CHAN-1:0]              ch_req_rdy,
  input  logic [NUM_CHAN*32-1:0]           ch_req_ip,
  input  logic [NUM_CHAN*NUM_QUEUES-1:0]   ch_req_port,
  input  logic [NUM_CHAN*META_WIDTH-1:0]   ch_req_meta,
  output logic                             arp_mac_vld,
  input  logic                             rd_arp_result,
  output logic [NUM_CHAN*48-1:0]           res_mac,
  output logic [NUM_CHAN*NUM_QUEUES-1:0]   res_port,
  output logic [NUM_CHAN*META_WIDTH-1:0]   res_meta,
  output logic [NUM_CHAN-1:0]              res_arp_hit,
  input  logic [LUT_DEPTH_BITS-1:0]        arp_rd_addr,
  input  logic                             arp_rd_req,
  output logic [47:0]                      arp_rd_mac,
  output logic [31:0]                      arp_rd_ip,
  output logic                             arp_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0]        arp_wr_addr,
  input  logic                             arp_wr_req,
  input  logic [47:0]                      arp_wr_mac,
  input  logic [31:0]                      arp_wr_ip,
  output logic                             arp_wr_ack,
  input  logic                             arp_cnt_clr,
  output logic [NUM_CHAN*16-1:0]           arp_miss_cnt
);
  localparam int CHW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int FDEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int EW     = 48 + NUM_QUEUES + META_WIDTH + 1;
  localparam int CW     = FIFO_DEPTH_BITS + 1;

  logic [31:0]               lut_ip  [LUT_DEPTH];
  logic [47:0]               lut_mac [LUT_DEPTH];
  logic                      wr_pend;
  logic [LUT_DEPTH_BITS-1:0] wr_addr_q;
  logic [31:0]               wr_ip_q;
  logic [47:0]               wr_mac_q;

  logic [CHW-1:0]            rr_ptr;
  logic [CHW-1:0]            grant_idx;
  logic                      grant_any;
  logic [CHW:0]              idx_sum;
  logic [NUM_CHAN-1:0]       eligible;
  logic [CW:0]               occ;

  logic                      s1_vld;
  logic [CHW-1:0]            s1_chan;
  logic [31:0]               s1_ip;
  logic [NUM_QUEUES-1:0]     s1_port;
  logic [META_WIDTH-1:0]     s1_meta;
  logic                      s1_hit;
  logic [47:0]               s1_mac;

  logic [EW-1:0]             fifo_mem [NUM_CHAN][FDEPTH];
  logic [FIFO_DEPTH_BITS-1:0] fifo_wp [NUM_CHAN];
  logic [FIFO_DEPTH_BITS-1:0] fifo_rp [NUM_CHAN];
  logic [CW-1:0]             fifo_cnt [NUM_CHAN];
  logic [NUM_CHAN-1:0]       push_vec;
  logic                      pop;
  logic [15:0]               miss_cnt [NUM_CHAN];

  // The in-flight stage-1 result already owns a FIFO slot, so it counts against occupancy.
  always_comb begin
    eligible = '0;
    occ      = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      occ = {1'b0, fifo_cnt[i]} + (CW+1)'(s1_vld && (s1_chan == CHW'(i)));
      eligible[i] = ch_req_vld[i] && !reset && (occ < (CW+1)'(FDEPTH));
    end
  end

  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    idx_sum    = '0;
    ch_req_rdy = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      idx_sum = {1'b0, rr_ptr} + (CHW+1)'(k);
      if (idx_sum >= (CHW+1)'(NUM_CHAN)) idx_sum = idx_sum - (CHW+1)'(NUM_CHAN);
      if (!grant_any && eligible[idx_sum[CHW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx_sum[CHW-1:0];
      end
    end
    if (grant_any) ch_req_rdy[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      s1_vld  <= 1'b0;
      s1_chan <= '0;
      s1_ip   <= '0;
      s1_port <= '0;
      s1_meta <= '0;
    end else begin
      s1_vld <= grant_any;
      if (grant_any) begin
        rr_ptr  <= (grant_idx == CHW'(NUM_CHAN-1)) ? '0 : grant_idx + 1'b1;
        s1_chan <= grant_idx;
        s1_ip   <= ch_req_ip[int'(grant_idx)*32 +: 32];
        s1_port <= ch_req_port[int'(grant_idx)*NUM_QUEUES +: NUM_QUEUES];
        s1_meta <= ch_req_meta[int'(grant_idx)*META_WIDTH +: META_WIDTH];
      end
    end
  end

  // Scanning downward lets the lowest matching index overwrite any higher match.
  always_comb begin
    s1_hit = 1'b0;
    s1_mac = '0;
    for (int e = LUT_DEPTH-1; e >= 0; e--) begin
      if (s1_ip != 32'd0 && lut_ip[e] == s1_ip) begin
        s1_hit = 1'b1;
        s1_mac = lut_mac[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < LUT_DEPTH; e++) begin
        lut_ip[e]  <= '0;
        lut_mac[e] <= '0;
      end
      wr_pend    <= 1'b0;
      wr_addr_q  <= '0;
      wr_ip_q    <= '0;
      wr_mac_q   <= '0;
      arp_rd_ack <= 1'b0;
      arp_rd_ip  <= '0;
      arp_rd_mac <= '0;
    end else begin
      wr_pend <= arp_wr_req;
      if (arp_wr_req) begin
        wr_addr_q <= arp_wr_addr;
        wr_ip_q   <= arp_wr_ip;
        wr_mac_q  <= arp_wr_mac;
      end
      if (wr_pend) begin
        lut_ip[wr_addr_q]  <= wr_ip_q;
        lut_mac[wr_addr_q] <= wr_mac_q;
      end
      arp_rd_ack <= arp_rd_req;
      if (arp_rd_req) begin
        arp_rd_ip  <= lut_ip[arp_rd_addr];
        arp_rd_mac <= lut_mac[arp_rd_addr];
      end
    end
  end

  assign arp_wr_ack = wr_pend;

  always_comb begin
    pop = rd_arp_result && arp_mac_vld;
    for (int i = 0; i < NUM_CHAN; i++) push_vec[i] = s1_vld && (s1_chan == CHW'(i));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHAN; i++)
      if (push_vec[i]) fifo_mem[i][fifo_wp[i]] <= {s1_mac, s1_port, s1_meta, s1_hit};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (reset) begin
        fifo_wp[i]  <= '0;
        fifo_rp[i]  <= '0;
        fifo_cnt[i] <= '0;
      end else begin
        if (push_vec[i]) fifo_wp[i] <= fifo_wp[i] + 1'b1;
        if (pop)         fifo_rp[i] <= fifo_rp[i] + 1'b1;
        fifo_cnt[i] <= fifo_cnt[i] + CW'(push_vec[i]) - CW'(pop);
      end
    end
  end

  // Clear takes priority over a miss landing in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (reset || arp_cnt_clr)
        miss_cnt[i] <= '0;
      else if (push_vec[i] && !s1_hit && miss_cnt[i] != 16'hFFFF)
        miss_cnt[i] <= miss_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    arp_mac_vld  = 1'b1;
    res_mac      = '0;
    res_port     = '0;
    res_meta     = '0;
    res_arp_hit  = '0;
    arp_miss_cnt = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      arp_miss_cnt[i*16 +: 16] = miss_cnt[i];
      if (fifo_cnt[i] == '0)
        arp_mac_vld = 1'b0;
      else
        {res_mac[i*48 +: 48], res_port[i*NUM_QUEUES +: NUM_QUEUES],
         res_meta[i*META_WIDTH +: META_WIDTH], res_arp_hit[i]} = fifo_mem[i][fifo_rp[i]];
    end
  end

endmodule

// File: tb/tb_ip_arp_mc.sv
// Bench for ip_arp_mc: directed scenarios then random traffic, every cycle compared against a
// queue-based reference model of the lookup table, arbiter, FIFOs and register port.
module tb_ip_arp_mc;
  localparam int NQ  = 8;
  localparam int NC  = 2;
  localparam int LD  = 32;
  localparam int LDB = 5;
  localparam int MW  = 3;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0]    ch_req_vld, ch_req_rdy, res_arp_hit;
  logic [NC*32-1:0] ch_req_ip;
  logic [NC*NQ-1:0] ch_req_port, res_port;
  logic [NC*MW-1:0] ch_req_meta, res_meta;
  logic             arp_mac_vld, rd_arp_result;
  logic [NC*48-1:0] res_mac;
  logic [LDB-1:0]   arp_rd_addr, arp_wr_addr;
  logic             arp_rd_req, arp_rd_ack, arp_wr_req, arp_wr_ack, arp_cnt_clr;
  logic [47:0]      arp_rd_mac, arp_wr_mac;
  logic [31:0]      arp_rd_ip, arp_wr_ip;
  logic [NC*16-1:0] arp_miss_cnt;

  always #5 clk = ~clk;

  ip_arp_mc #(.NUM_QUEUES(NQ), .NUM_CHAN(NC), .LUT_DEPTH(LD), .LUT_DEPTH_BITS(LDB),
              .META_WIDTH(MW), .FIFO_DEPTH_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy), .ch_req_ip(ch_req_ip),
    .ch_req_port(ch_req_port), .ch_req_meta(ch_req_meta),
    .arp_mac_vld(arp_mac_vld), .rd_arp_result(rd_arp_result),
    .res_mac(res_mac), .res_port(res_port), .res_meta(res_meta), .res_arp_hit(res_arp_hit),
    .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req), .arp_rd_mac(arp_rd_mac),
    .arp_rd_ip(arp_rd_ip), .arp_rd_ack(arp_rd_ack),
    .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req), .arp_wr_mac(arp_wr_mac),
    .arp_wr_ip(arp_wr_ip), .arp_wr_ack(arp_wr_ack),
    .arp_cnt_clr(arp_cnt_clr), .arp_miss_cnt(arp_miss_cnt)
  );

  typedef struct {
    logic [47:0]   mac;
    logic [NQ-1:0] port;
    logic [MW-1:0] meta;
    logic          hit;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;
  int acc0    = 0;

  res_t        mq [NC][$];
  logic [31:0] m_ip  [LD];
  logic [47:0] m_mac [LD];
  int          m_miss [NC];
  int          m_rr, m_s1_chan, m_wr_addr;
  bit          m_s1_vld, m_wr_pend, m_rd_ack;
  logic [31:0] m_s1_ip, m_wr_ip, m_rd_ip;
  logic [NQ-1:0] m_s1_port;
  logic [MW-1:0] m_s1_meta;
  logic [47:0] m_wr_mac, m_rd_mac;
  logic [31:0] ip_pool [7];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      m_miss[i] = 0;
    end
    for (int e = 0; e < LD; e++) begin
      m_ip[e]  = '0;
      m_mac[e] = '0;
    end
    m_rr = 0; m_s1_vld = 0; m_s1_chan = 0; m_s1_ip = '0; m_s1_port = '0; m_s1_meta = '0;
    m_wr_pend = 0; m_wr_addr = 0; m_wr_ip = '0; m_wr_mac = '0;
    m_rd_ack = 0; m_rd_ip = '0; m_rd_mac = '0;
  endtask

  function automatic res_t lookup(input logic [31:0] ip);
    res_t r;
    r.mac = '0; r.port = '0; r.meta = '0; r.hit = 1'b0;
    if (ip != 32'd0)
      for (int e = 0; e < LD; e++)
        if (!r.hit && m_ip[e] == ip) begin
          r.hit = 1'b1;
          r.mac = m_mac[e];
        end
    return r;
  endfunction

  task automatic idle_inputs();
    ch_req_vld = '0; ch_req_ip = '0; ch_req_port = '0; ch_req_meta = '0;
    rd_arp_result = 1'b0; arp_rd_req = 1'b0; arp_rd_addr = '0;
    arp_wr_req = 1'b0; arp_wr_addr = '0; arp_wr_ip = '0; arp_wr_mac = '0; arp_cnt_clr = 1'b0;
  endtask

  // Called at a falling edge with inputs applied; compares, then advances the model one clock.
  task automatic step_cycle();
    logic [NC-1:0] exp_rdy;
    int g, c, occ;
    bit all_ne, do_pop;
    res_t r, h;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!reset)
      for (int k = 0; k < NC; k++) begin
        c = (m_rr + k) % NC;
        occ = mq[c].size() + ((m_s1_vld && m_s1_chan == c) ? 1 : 0);
        if (g < 0 && ch_req_vld[c] && occ < FD) g = c;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_output("rdy", 64'(ch_req_rdy), 64'(exp_rdy));
    if (ch_req_rdy[0] === 1'b1) acc0++;
    all_ne = 1;
    for (int i = 0; i < NC; i++) if (mq[i].size() == 0) all_ne = 0;
    check_output("mac_vld", 64'(arp_mac_vld), 64'(all_ne));
    for (int i = 0; i < NC; i++) begin
      h.mac = '0; h.port = '0; h.meta = '0; h.hit = 1'b0;
      if (mq[i].size() > 0) h = mq[i][0];
      check_output("res_mac",  64'(res_mac[i*48 +: 48]),  64'(h.mac));
      check_output("res_port", 64'(res_port[i*NQ +: NQ]), 64'(h.port));
      check_output("res_meta", 64'(res_meta[i*MW +: MW]), 64'(h.meta));
      check_output("res_hit",  64'(res_arp_hit[i]),       64'(h.hit));
      check_output("miss_cnt", 64'(arp_miss_cnt[i*16 +: 16]), 64'(m_miss[i]));
    end
    check_output("wr_ack", 64'(arp_wr_ack), 64'(m_wr_pend));
    check_output("rd_ack", 64'(arp_rd_ack), 64'(m_rd_ack));
    check_output("rd_ip",  64'(arp_rd_ip),  64'(m_rd_ip));
    check_output("rd_mac", 64'(arp_rd_mac), 64'(m_rd_mac));
    do_pop = rd_arp_result && all_ne;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (do_pop) for (int i = 0; i < NC; i++) void'(mq[i].pop_front());
      if (m_s1_vld) begin
        r = lookup(m_s1_ip);
        r.port = m_s1_port;
        r.meta = m_s1_meta;
        mq[m_s1_chan].push_back(r);
        if (!r.hit && m_miss[m_s1_chan] < 16'hFFFF) m_miss[m_s1_chan]++;
      end
      if (arp_cnt_clr) for (int i = 0; i < NC; i++) m_miss[i] = 0;
      m_rd_ack = arp_rd_req;
      if (arp_rd_req) begin
        m_rd_ip  = m_ip[arp_rd_addr];
        m_rd_mac = m_mac[arp_rd_addr];
      end
      if (m_wr_pend) begin
        m_ip[m_wr_addr]  = m_wr_ip;
        m_mac[m_wr_addr] = m_wr_mac;
      end
      m_wr_pend = arp_wr_req;
      if (arp_wr_req) begin
        m_wr_addr = int'(arp_wr_addr);
        m_wr_ip   = arp_wr_ip;
        m_wr_mac  = arp_wr_mac;
      end
      m_s1_vld = (g >= 0);
      if (g >= 0) begin
        m_s1_chan = g;
        m_s1_ip   = ch_req_ip[g*32 +: 32];
        m_s1_port = ch_req_port[g*NQ +: NQ];
        m_s1_meta = ch_req_meta[g*MW +: MW];
        m_rr      = (g + 1) % NC;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    ip_pool[0] = 32'h0;
    for (int i = 1; i < 7; i++) ip_pool[i] = 32'h0A000000 + 32'(i);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    step_cycle();
    reset = 1'b0;
    step_cycle();

    // Single hit on both channels, one cycle apart
    arp_wr_req = 1'b1; arp_wr_addr = 5'd3; arp_wr_ip = 32'h0A000001; arp_wr_mac = 48'h001122334455;
    step_cycle();
    idle_inputs();
    check_output("wr_ack_pulse", 64'(arp_wr_ack), 64'd1);
    step_cycle();
    ch_req_vld = 2'b01; ch_req_ip[31:0] = 32'h0A000001; ch_req_port[7:0] = 8'h01; ch_req_meta[2:0] = 3'b101;
    step_cycle();
    idle_inputs();
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000001; ch_req_port[15:8] = 8'h02; ch_req_meta[5:3] = 3'b011;
    step_cycle();
    idle_inputs();
    check_output("vld_t2", 64'(arp_mac_vld), 64'd0);
    step_cycle();
    check_output("vld_t3", 64'(arp_mac_vld), 64'd1);
    check_output("hit_mac0", 64'(res_mac[47:0]), 64'h001122334455);
    check_output("hit_mac1", 64'(res_mac[95:48]), 64'h001122334455);
    check_output("hit_flags", 64'(res_arp_hit), 64'd3);

    // Round-robin with both channels requesting and popping every cycle
    for (int k = 0; k < 6; k++) begin
      ch_req_vld = 2'b11; ch_req_ip = {32'h0A000001, 32'h0A000005};
      ch_req_port = 16'h8010; rd_arp_result = 1'b1;
      #1;
      check_output("rr_grant", 64'(ch_req_rdy), (k % 2 == 0) ? 64'd1 : 64'd2);
      step_cycle();
    end
    idle_inputs();
    rd_arp_result = 1'b1;
    for (int k = 0; k < 6; k++) step_cycle();

    // Backpressure: ch0 fills, pops are ignored while ch1 is empty
    acc0 = 0;
    for (int k = 0; k < 7; k++) begin
      ch_req_vld = 2'b01; ch_req_ip[31:0] = 32'h0A000001; rd_arp_result = 1'b1;
      step_cycle();
    end
    check_output("bp_accepted", 64'(acc0), 64'd4);
    #1;
    check_output("bp_rdy0", 64'(ch_req_rdy[0]), 64'd0);
    idle_inputs();
    step_cycle();
    check_output("bp_head", 64'(res_mac[47:0]), 64'h001122334455);

    // Miss, then a clear coinciding with a second miss
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000009; ch_req_port[15:8] = 8'h40;
    step_cycle();
    idle_inputs();
    step_cycle();
    step_cycle();
    check_output("miss_hit1", 64'(res_arp_hit[1]), 64'd0);
    check_output("miss_mac1", 64'(res_mac[95:48]), 64'd0);
    check_output("miss_cnt1", 64'(arp_miss_cnt[31:16]), 64'd1);
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000009;
    step_cycle();
    idle_inputs();
    arp_cnt_clr = 1'b1;
    step_cycle();
    idle_inputs();
    check_output("clr_wins", 64'(arp_miss_cnt[31:16]), 64'd0);

    // Write/lookup collision on entry 3
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000001;
    arp_wr_req = 1'b1; arp_wr_addr = 5'd3; arp_wr_ip = 32'h0A000001; arp_wr_mac = 48'hAABBCCDDEEFF;
    step_cycle();
    idle_inputs();
    step_cycle();
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000001;
    step_cycle();
    idle_inputs();
    step_cycle();
    step_cycle();
    rd_arp_result = 1'b1;
    step_cycle();
    step_cycle();
    check_output("coll_old", 64'(res_mac[95:48]), 64'h001122334455);
    step_cycle();
    idle_inputs();
    check_output("coll_new", 64'(res_mac[95:48]), 64'hAABBCCDDEEFF);

    // Reset with results queued and one lookup in flight
    ch_req_vld = 2'b10; ch_req_ip[63:32] = 32'h0A000009;
    step_cycle();
    idle_inputs();
    ch_req_vld = 2'b01; ch_req_ip[31:0] = 32'h0A000001;
    step_cycle();
    idle_inputs();
    check_output("pre_rst_cnt", 64'(arp_miss_cnt[31:16]), 64'd1);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    arp_rd_req = 1'b1; arp_rd_addr = 5'd3;
    step_cycle();
    idle_inputs();
    check_output("rst_rd_ack", 64'(arp_rd_ack), 64'd1);
    check_output("rst_rd_ip", 64'(arp_rd_ip), 64'd0);
    check_output("rst_rd_mac", 64'(arp_rd_mac), 64'd0);
    check_output("rst_vld", 64'(arp_mac_vld), 64'd0);
    check_output("rst_cnt", 64'(arp_miss_cnt), 64'd0);
    step_cycle();

    // Random traffic against the model, with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      reset = (n == 300);
      for (int c = 0; c < NC; c++) begin
        ch_req_vld[c] = ($urandom_range(0, 9) < 7);
        ch_req_ip[c*32 +: 32] = ip_pool[$urandom_range(0, 6)];
      end
      ch_req_port   = (NC*NQ)'($urandom);
      ch_req_meta   = (NC*MW)'($urandom);
      rd_arp_result = 1'($urandom_range(0, 1));
      arp_wr_req    = ($urandom_range(0, 3) == 0);
      arp_wr_addr   = LDB'($urandom_range(0, 7));
      arp_wr_ip     = ip_pool[$urandom_range(0, 6)];
      arp_wr_mac    = {16'($urandom), $urandom};
      arp_rd_req    = 1'($urandom_range(0, 1));
      arp_rd_addr   = LDB'($urandom_range(0, 7));
      arp_cnt_clr   = ($urandom_range(0, 49) == 0);
      step_cycle();
    end
    reset = 1'b0;
    idle_inputs();
    step_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
